vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving system clocks per pixel (legal range 1..16).
REQ-002 The block SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, giving horizontal timing in pixels.
REQ-003 The block SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, giving vertical timing in lines.
REQ-004 The block SHALL have parameter SYNC_POL, default 0, giving the asserted sync level (0 = active-low).
REQ-005 The block SHALL have parameter COORD_SIZE, default 10, giving the coordinate width.
REQ-006 clk_i  input  1  system clock; the block SHALL use this single clock.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 pixelTick_o  output  1  one-clock pulse per pixel period.
REQ-009 hsync_o  output  1  horizontal sync.
REQ-010 vsync_o  output  1  vertical sync.
REQ-011 inActiveArea_o  output  1  high while the current pixel is visible; drives the RGB mux inActiveArea_i.
REQ-012 x_o  output  COORD_SIZE  current horizontal pixel counter.
REQ-013 y_o  output  COORD_SIZE  current line counter.
REQ-014 frameStart_o  output  1  one-clock pulse at pixel (0,0).

Function
REQ-015 Divider counter SHALL count 0..CLK_DIV-1 and wrap; the pixel tick is defined as the cycle in which it equals CLK_DIV-1 (with CLK_DIV=1, the tick is active every cycle).
REQ-016 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-017 On each pixel tick, the h counter SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and the v counter SHALL advance on the same tick.
REQ-018 The v counter SHALL wrap from V_TOTAL-1 to 0 on the tick where h wraps; the h and v wraps SHALL occur in the same cycle.
REQ-019 Counters SHALL hold between ticks.
REQ-020 All outputs SHALL be registered and SHALL reflect the counter values updated on the previous clock edge, giving a latency of 1 clock.
REQ-021 hsync_o SHALL equal SYNC_POL when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and ~SYNC_POL otherwise.
REQ-022 vsync_o SHALL equal SYNC_POL when v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], and ~SYNC_POL otherwise; vsync SHALL be decoded from v only.
REQ-023 inActiveArea_o SHALL be 1 exactly when h<H_ACTIVE and v<V_ACTIVE.
REQ-024 x_o and y_o SHALL carry the raw h and v counts, including blanking.
REQ-025 frameStart_o SHALL be high for exactly one clock, in the first clock after h and v both become 0 on a tick.
REQ-026 pixelTick_o SHALL be registered, and SHALL be aligned with the clock in which the new x_o and y_o values first appear.
REQ-027 Counter widths SHALL hold H_TOTAL-1 and V_TOTAL-1; COORD_SIZE SHALL be at least clog2(max(H_TOTAL,V_TOTAL)), and elaboration SHALL fail otherwise.

Reset
REQ-028 While rst_i is high, the divider, h and v counters SHALL be 0.
REQ-029 While rst_i is high, hsync_o and vsync_o SHALL be ~SYNC_POL.
REQ-030 While rst_i is high, inActiveArea_o, pixelTick_o, frameStart_o, x_o and y_o SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately, with no wait for a clock edge.
REQ-032 After reset release, the first clock SHALL present x=0, y=0 and inActiveArea_o=1; that clock SHALL NOT be flagged by frameStart_o.
REQ-033 The first frameStart_o after reset SHALL occur at the first full frame wrap.

Structure
REQ-034 Default timing constants (640x480@60) and the sync polarity encoding SHALL live in shared package vga_pkg.
REQ-035 The divider SHALL be the sub-module vga_pixel_tick (clk_i, rst_i, tick_o, parameter CLK_DIV).

Verification
REQ-036 Defaults, reset released: the bench SHALL check pixelTick_o every 4 clocks, x_o 0..799 wrapping, y_o increment on each x_o wrap to 0, and 800*525*4 = 1,680,000 clocks between frameStart_o pulses.
REQ-037 Defaults: the bench SHALL check hsync_o=0 exactly for x_o in 656..751 (96 pixels), and vsync_o=0 exactly for y_o in 490..491 across whole lines.
REQ-038 Defaults: the bench SHALL check inActiveArea_o=1 for x_o<640 and y_o<480 only, with 307,200 active pixel ticks per frame.
REQ-039 CLK_DIV=1, SYNC_POL=1: the bench SHALL check pixelTick_o constantly high, hsync_o=1 for x_o in 656..751, and 420,000 clocks per frame.
REQ-040 rst_i pulsed asynchronously at x_o=300, y_o=200: the bench SHALL check that outputs go to reset values before the next edge, and that after release the count restarts at (0,0) and the next frameStart_o follows 1,680,000 clocks later.
REQ-041 Wrap corner: at x_o=799, y_o=524 followed by a tick, the bench SHALL check x_o=0, y_o=0 and frameStart_o=1 in the same clock, with vsync_o deasserted.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), sync polarity encoding
// and small elaboration helpers used by the timing generator.
package vga_pkg;

   localparam int unsigned DEF_CLK_DIV    = 4;
   localparam int unsigned DEF_H_ACTIVE   = 640;
   localparam int unsigned DEF_H_FP       = 16;
   localparam int unsigned DEF_H_SYNC     = 96;
   localparam int unsigned DEF_H_BP       = 48;
   localparam int unsigned DEF_V_ACTIVE   = 480;
   localparam int unsigned DEF_V_FP       = 10;
   localparam int unsigned DEF_V_SYNC     = 2;
   localparam int unsigned DEF_V_BP       = 33;
   localparam int unsigned DEF_COORD_SIZE = 10;

   // Level driven on a sync line while the sync pulse is asserted.
   typedef enum logic {
      SYNC_ACTIVE_LOW  = 1'b0,
      SYNC_ACTIVE_HIGH = 1'b1
   } sync_pol_e;

   // Sync output level for a given polarity and "inside sync window" flag.
   function automatic logic sync_level(input logic pol, input logic asserted);
      return asserted ? pol : ~pol;
   endfunction

   // Larger of two unsigned values, used when sizing coordinate counters.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel clock-enable generator: divides the system clock by CLK_DIV and
// flags the last system clock of every pixel period.
module vga_pixel_tick #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   // A one-bit counter is kept even for CLK_DIV=1 so the logic stays uniform.
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   generate
      if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_div_range_chk
         $error("vga_pixel_tick: CLK_DIV must be in 1..16");
      end
   endgenerate

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   // Next divider value: count 0..CLK_DIV-1 and wrap.
   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (div_q == DIV_LAST) begin
         div_d = '0;
      end
   end

   // Divider register, cleared immediately by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign tick_o = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters advanced on the pixel tick,
// with registered sync, active-area, coordinate and frame-start outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter logic        SYNC_POL   = SYNC_ACTIVE_LOW,
   parameter int unsigned COORD_SIZE = DEF_COORD_SIZE
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  pixelTick_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  inActiveArea_o,
   output logic [COORD_SIZE-1:0] x_o,
   output logic [COORD_SIZE-1:0] y_o,
   output logic                  frameStart_o
);

   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned COORD_MIN = $clog2(max_u(H_TOTAL, V_TOTAL));

   localparam logic [COORD_SIZE-1:0] H_LAST      = COORD_SIZE'(H_TOTAL - 1);
   localparam logic [COORD_SIZE-1:0] V_LAST      = COORD_SIZE'(V_TOTAL - 1);
   localparam logic [COORD_SIZE-1:0] H_ACT_END   = COORD_SIZE'(H_ACTIVE);
   localparam logic [COORD_SIZE-1:0] V_ACT_END   = COORD_SIZE'(V_ACTIVE);
   localparam logic [COORD_SIZE-1:0] H_SYNC_BEG  = COORD_SIZE'(H_ACTIVE + H_FP);
   localparam logic [COORD_SIZE-1:0] H_SYNC_LAST = COORD_SIZE'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_SIZE-1:0] V_SYNC_BEG  = COORD_SIZE'(V_ACTIVE + V_FP);
   localparam logic [COORD_SIZE-1:0] V_SYNC_LAST = COORD_SIZE'(V_ACTIVE + V_FP + V_SYNC - 1);

   generate
      if (COORD_SIZE < COORD_MIN) begin : g_coord_size_chk
         $error("vga_timing_gen: COORD_SIZE too narrow for H_TOTAL/V_TOTAL");
      end
   endgenerate

   logic                  tick;
   logic [COORD_SIZE-1:0] h_q, h_d;
   logic [COORD_SIZE-1:0] v_q, v_d;

   // Set when the counters moved on the previous edge; delays the tick so
   // pixelTick_o lines up with the first clock showing the new coordinates.
   logic                  adv_q;
   logic                  pixelTick_q, pixelTick_d;
   logic                  frameStart_q, frameStart_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   logic                  active_q, active_d;
   logic [COORD_SIZE-1:0] x_q, x_d;
   logic [COORD_SIZE-1:0] y_q, y_d;

   vga_pixel_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick)
   );

   // Counter next state: advance h on each tick; on h wrap advance v in the
   // same tick, wrapping v at the end of the frame.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d = '0;
            end else begin
               v_d = v_q + COORD_SIZE'(1);
            end
         end else begin
            h_d = h_q + COORD_SIZE'(1);
         end
      end
   end

   // h/v counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Output decode from the current counter values; registered below so the
   // pins carry the counters as they stood after the previous edge.
   always_comb begin
      pixelTick_d  = adv_q;
      frameStart_d = adv_q && (h_q == '0) && (v_q == '0);
      hsync_d      = sync_level(SYNC_POL, (h_q >= H_SYNC_BEG) && (h_q <= H_SYNC_LAST));
      vsync_d      = sync_level(SYNC_POL, (v_q >= V_SYNC_BEG) && (v_q <= V_SYNC_LAST));
      active_d     = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      x_d          = h_q;
      y_d          = v_q;
   end

   // Output registers; reset drives the idle levels immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         adv_q        <= 1'b0;
         pixelTick_q  <= 1'b0;
         frameStart_q <= 1'b0;
         hsync_q      <= ~SYNC_POL;
         vsync_q      <= ~SYNC_POL;
         active_q     <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
      end else begin
         adv_q        <= tick;
         pixelTick_q  <= pixelTick_d;
         frameStart_q <= frameStart_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         active_q     <= active_d;
         x_q          <= x_d;
         y_q          <= y_d;
      end
   end

   assign pixelTick_o    = pixelTick_q;
   assign frameStart_o   = frameStart_q;
   assign hsync_o        = hsync_q;
   assign vsync_o        = vsync_q;
   assign inActiveArea_o = active_q;
   assign x_o            = x_q;
   assign y_o            = y_q;

endmodule
